// File: rtl/stage_instruction_decode.sv
// -----------------------------------------------------------------------------
// stage_instruction_decode
//   Decode stage of the 5-stage RV32I pipeline. Reads the 32x32 register
//   file, builds the sign-extended immediate and the control word for the
//   instruction coming from fetch, and registers all of it into the DE->EX
//   pipeline register.
//
//   Ports
//     clk, reset            clock (rising edge), synchronous active-high reset
//     ex_clear, ex_stall    bubble / hold for the DE->EX register (clear wins)
//     de_instr, de_pc,
//     de_pc_plus4           instruction and PCs from the fetch stage
//     wb_reg_write, wb_rd,
//     wb_result             register-file write port from the WB stage
//     de_rs1, de_rs2        combinational source indices for the hazard unit
//     ex_*                  registered operands, immediate, indices, PCs and
//                           control for the execute stage
//
//   Configuration macro
//     STAGE_DECODE_WB_BYPASS_EN  when defined, a read of the register being
//                                written back in the same cycle returns
//                                wb_result (write-first). When undefined the
//                                stored value is returned and the hazard unit
//                                is expected to stall.
// -----------------------------------------------------------------------------
module stage_instruction_decode #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            ex_clear,
   input  logic            ex_stall,
   input  logic [31:0]     de_instr,
   input  logic [XLEN-1:0] de_pc,
   input  logic [XLEN-1:0] de_pc_plus4,
   input  logic            wb_reg_write,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_result,
   output logic [4:0]      de_rs1,
   output logic [4:0]      de_rs2,
   output logic [XLEN-1:0] ex_rd1,
   output logic [XLEN-1:0] ex_rd2,
   output logic [XLEN-1:0] ex_imm,
   output logic [4:0]      ex_rs1,
   output logic [4:0]      ex_rs2,
   output logic [4:0]      ex_rd,
   output logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] ex_pc_plus4,
   output logic            ex_reg_write,
   output logic            ex_mem_write,
   output logic            ex_jump,
   output logic            ex_branch,
   output logic            ex_alu_src,
   output logic            ex_illegal,
   output logic [1:0]      ex_result_src,
   output logic [3:0]      ex_alu_ctrl,
   output logic [2:0]      ex_funct3
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I_ALU  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_AND   = 4'd2;
   localparam logic [3:0] ALU_OR    = 4'd3;
   localparam logic [3:0] ALU_XOR   = 4'd4;
   localparam logic [3:0] ALU_SLT   = 4'd5;
   localparam logic [3:0] ALU_SLTU  = 4'd6;
   localparam logic [3:0] ALU_SLL   = 4'd7;
   localparam logic [3:0] ALU_SRL   = 4'd8;
   localparam logic [3:0] ALU_SRA   = 4'd9;
   localparam logic [3:0] ALU_PASSB = 4'd10;

   localparam logic [1:0] RES_ALU   = 2'b00;
   localparam logic [1:0] RES_MEM   = 2'b01;
   localparam logic [1:0] RES_PC4   = 2'b10;

   typedef enum logic [2:0] {
      IMM_NONE,
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_J,
      IMM_U
   } imm_sel_t;

   typedef struct packed {
      logic [XLEN-1:0] rd1;
      logic [XLEN-1:0] rd2;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_plus4;
      logic            reg_write;
      logic            mem_write;
      logic            jump;
      logic            branch;
      logic            alu_src;
      logic            illegal;
      logic [1:0]      result_src;
      logic [3:0]      alu_ctrl;
      logic [2:0]      funct3;
   } ex_t;

   // Arithmetic op for R / I-ALU encodings. allow_sub is 0 for I-ALU, where
   // bit 30 is part of the immediate for funct3=000 and must not select SUB.
   function automatic logic [3:0] alu_from_funct3(input logic [2:0] funct3,
                                                  input logic       f7b5,
                                                  input logic       allow_sub);
      logic [3:0] op;
      case (funct3)
         3'b000:  op = (f7b5 && allow_sub) ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         3'b111:  op = ALU_AND;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

   logic [XLEN-1:0] regs_r [NREGS];
   ex_t             ex_r;
   ex_t             ex_next_s;

   logic [6:0]      opcode_s;
   logic [2:0]      funct3_s;
   logic [4:0]      rd_idx_s;
   logic            f7b5_s;
   logic [XLEN-1:0] rd1_s;
   logic [XLEN-1:0] rd2_s;
   logic [XLEN-1:0] imm_s;
   imm_sel_t        imm_sel_s;
   logic            reg_write_s;
   logic            mem_write_s;
   logic            jump_s;
   logic            branch_s;
   logic            alu_src_s;
   logic            illegal_s;
   logic [1:0]      result_src_s;
   logic [3:0]      alu_ctrl_s;

   assign opcode_s = de_instr[6:0];
   assign rd_idx_s = de_instr[11:7];
   assign funct3_s = de_instr[14:12];
   assign de_rs1   = de_instr[19:15];
   assign de_rs2   = de_instr[24:20];
   assign f7b5_s   = de_instr[30];

   // Register-file read ports; x0 always reads zero.
   always_comb begin
      rd1_s = '0;
      rd2_s = '0;
      if (de_rs1 == 5'd0) begin
         rd1_s = '0;
      end else begin
`ifdef STAGE_DECODE_WB_BYPASS_EN
         if (wb_reg_write && (wb_rd == de_rs1)) begin
            rd1_s = wb_result;
         end else begin
            rd1_s = regs_r[de_rs1];
         end
`else
         rd1_s = regs_r[de_rs1];
`endif
      end
      if (de_rs2 == 5'd0) begin
         rd2_s = '0;
      end else begin
`ifdef STAGE_DECODE_WB_BYPASS_EN
         if (wb_reg_write && (wb_rd == de_rs2)) begin
            rd2_s = wb_result;
         end else begin
            rd2_s = regs_r[de_rs2];
         end
`else
         rd2_s = regs_r[de_rs2];
`endif
      end
   end

   // Control decode by opcode; an all-zero word is a fetch bubble, not illegal.
   always_comb begin
      reg_write_s  = 1'b0;
      mem_write_s  = 1'b0;
      jump_s       = 1'b0;
      branch_s     = 1'b0;
      alu_src_s    = 1'b0;
      illegal_s    = 1'b0;
      result_src_s = RES_ALU;
      alu_ctrl_s   = ALU_ADD;
      imm_sel_s    = IMM_NONE;
      case (opcode_s)
         OP_R: begin
            reg_write_s = 1'b1;
            alu_ctrl_s  = alu_from_funct3(funct3_s, f7b5_s, 1'b1);
         end
         OP_I_ALU: begin
            reg_write_s = 1'b1;
            alu_src_s   = 1'b1;
            alu_ctrl_s  = alu_from_funct3(funct3_s, f7b5_s, 1'b0);
            imm_sel_s   = IMM_I;
         end
         OP_LOAD: begin
            reg_write_s  = 1'b1;
            alu_src_s    = 1'b1;
            result_src_s = RES_MEM;
            imm_sel_s    = IMM_I;
         end
         OP_STORE: begin
            mem_write_s = 1'b1;
            alu_src_s   = 1'b1;
            imm_sel_s   = IMM_S;
         end
         OP_BRANCH: begin
            branch_s   = 1'b1;
            alu_ctrl_s = ALU_SUB;
            imm_sel_s  = IMM_B;
         end
         OP_JAL: begin
            jump_s       = 1'b1;
            reg_write_s  = 1'b1;
            result_src_s = RES_PC4;
            imm_sel_s    = IMM_J;
         end
         OP_JALR: begin
            jump_s       = 1'b1;
            reg_write_s  = 1'b1;
            alu_src_s    = 1'b1;
            result_src_s = RES_PC4;
            imm_sel_s    = IMM_I;
         end
         OP_LUI: begin
            reg_write_s = 1'b1;
            alu_src_s   = 1'b1;
            alu_ctrl_s  = ALU_PASSB;
            imm_sel_s   = IMM_U;
         end
         default: begin
            illegal_s = (de_instr != 32'h0000_0000);
         end
      endcase
   end

   // Immediate generation, sign-extended from instr[31].
   always_comb begin
      imm_s = '0;
      case (imm_sel_s)
         IMM_I:   imm_s = {{20{de_instr[31]}}, de_instr[31:20]};
         IMM_S:   imm_s = {{20{de_instr[31]}}, de_instr[31:25], de_instr[11:7]};
         IMM_B:   imm_s = {{19{de_instr[31]}}, de_instr[31], de_instr[7],
                           de_instr[30:25], de_instr[11:8], 1'b0};
         IMM_J:   imm_s = {{11{de_instr[31]}}, de_instr[31], de_instr[19:12],
                           de_instr[20], de_instr[30:21], 1'b0};
         IMM_U:   imm_s = {de_instr[31:12], 12'h000};
         default: imm_s = '0;
      endcase
   end

   // Assemble the word loaded into the DE->EX register.
   always_comb begin
      ex_next_s            = '0;
      ex_next_s.rd1        = rd1_s;
      ex_next_s.rd2        = rd2_s;
      ex_next_s.imm        = imm_s;
      ex_next_s.rs1        = de_rs1;
      ex_next_s.rs2        = de_rs2;
      ex_next_s.rd         = rd_idx_s;
      ex_next_s.pc         = de_pc;
      ex_next_s.pc_plus4   = de_pc_plus4;
      ex_next_s.reg_write  = reg_write_s;
      ex_next_s.mem_write  = mem_write_s;
      ex_next_s.jump       = jump_s;
      ex_next_s.branch     = branch_s;
      ex_next_s.alu_src    = alu_src_s;
      ex_next_s.illegal    = illegal_s;
      ex_next_s.result_src = result_src_s;
      ex_next_s.alu_ctrl   = alu_ctrl_s;
      ex_next_s.funct3     = funct3_s;
   end

   // Register file storage; x0 is never written. Writes continue during stalls.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_r[i] <= '0;
         end
      end else if (wb_reg_write && (wb_rd != 5'd0)) begin
         regs_r[wb_rd] <= wb_result;
      end
   end

   // DE->EX pipeline register: reset > clear > stall > load.
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_r <= '0;
      end else if (ex_clear) begin
         ex_r <= '0;
      end else if (ex_stall) begin
         ex_r <= ex_r;
      end else begin
         ex_r <= ex_next_s;
      end
   end

   assign ex_rd1        = ex_r.rd1;
   assign ex_rd2        = ex_r.rd2;
   assign ex_imm        = ex_r.imm;
   assign ex_rs1        = ex_r.rs1;
   assign ex_rs2        = ex_r.rs2;
   assign ex_rd         = ex_r.rd;
   assign ex_pc         = ex_r.pc;
   assign ex_pc_plus4   = ex_r.pc_plus4;
   assign ex_reg_write  = ex_r.reg_write;
   assign ex_mem_write  = ex_r.mem_write;
   assign ex_jump       = ex_r.jump;
   assign ex_branch     = ex_r.branch;
   assign ex_alu_src    = ex_r.alu_src;
   assign ex_illegal    = ex_r.illegal;
   assign ex_result_src = ex_r.result_src;
   assign ex_alu_ctrl   = ex_r.alu_ctrl;
   assign ex_funct3     = ex_r.funct3;

endmodule
